// File: rtl/axi_xbar_pkg.sv
// Shared types and helpers for the AXI crossbar channel routers.
// Region tables are widened to MAX_PORTS x MAX_ADDR so the helpers serve any parameter set.
package axi_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2
    } xbar_state_e;

    localparam int ID_PREFIX_BITS = 4;
    localparam int MAX_PORTS      = 16;
    localparam int MAX_ADDR       = 64;

    typedef logic [MAX_PORTS-1:0][MAX_ADDR-1:0] region_tbl_t;

    // Lowest-indexed matching region wins, so scan downwards and let later hits overwrite.
    function automatic logic [3:0] decode_slave(input logic [MAX_ADDR-1:0] addr,
                                                input region_tbl_t base,
                                                input region_tbl_t mask,
                                                input int num_s,
                                                input logic [3:0] dflt);
        logic [3:0] idx;
        idx = dflt;
        for (int s = MAX_PORTS-1; s >= 0; s--) begin
            if (s < num_s && (addr & mask[s[3:0]]) == base[s[3:0]])
                idx = s[3:0];
        end
        return idx;
    endfunction

    function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                           input logic [3:0] ptr,
                                           input int num);
        logic [3:0] idx;
        int c;
        idx = '0;
        for (int k = MAX_PORTS-1; k >= 0; k--) begin
            if (k < num) begin
                c = (int'(ptr) + k) % num;
                if (req[c[3:0]])
                    idx = c[3:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping at N-1.
module axi_rr_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [3:0]   ptr_i,
    output logic [3:0]   grant_o,
    output logic         any_o
);

    logic [MAX_PORTS-1:0] req_ext;

    assign req_ext = MAX_PORTS'(req_i);
    assign grant_o = rr_pick(req_ext, ptr_i, N);
    assign any_o   = |req_i;

endmodule

// File: rtl/axi_aw_xbar.sv
// Write-address router: NUM_M masters to NUM_S slaves with a registered grant
// that stays put until the W channel reports the end of the burst.
module axi_aw_xbar
    import axi_xbar_pkg::*;
#(
    parameter int NUM_M     = 2,
    parameter int NUM_S     = 2,
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = ID_BITS + 4,
    parameter int ADDR_BITS = 32,
    parameter logic [NUM_S*ADDR_BITS-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_S*ADDR_BITS-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int DEFAULT_SLAVE = 0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [NUM_M*ID_BITS-1:0]   AWID_M,
    input  logic [NUM_M*ADDR_BITS-1:0] AWADDR_M,
    input  logic [NUM_M*4-1:0]         AWLEN_M,
    input  logic [NUM_M*3-1:0]         AWSIZE_M,
    input  logic [NUM_M*2-1:0]         AWBURST_M,
    input  logic [NUM_M-1:0]           AWVALID_M,
    output logic [NUM_M-1:0]           AWREADY_M,
    output logic [NUM_S*IDS_BITS-1:0]  AWID_S,
    output logic [NUM_S*ADDR_BITS-1:0] AWADDR_S,
    output logic [NUM_S*4-1:0]         AWLEN_S,
    output logic [NUM_S*3-1:0]         AWSIZE_S,
    output logic [NUM_S*2-1:0]         AWBURST_S,
    output logic [NUM_S-1:0]           AWVALID_S,
    input  logic [NUM_S-1:0]           AWREADY_S,
    input  logic                       w_done,
    output logic                       grant_valid,
    output logic [3:0]                 grant_m,
    output logic [3:0]                 grant_s
);

    xbar_state_e state_q, state_d;
    logic [3:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  grant_m_q, grant_m_d;
    logic [3:0]  grant_s_q, grant_s_d;

    region_tbl_t base_tbl, mask_tbl;
    logic [3:0]  arb_grant, dec_slave;
    logic        arb_any;

    logic [ADDR_BITS-1:0] arb_addr, g_addr;
    logic [ID_BITS-1:0]   g_id;
    logic [3:0]           g_len;
    logic [2:0]           g_size;
    logic [1:0]           g_burst;
    logic                 g_valid, g_ready;

    always_comb begin
        base_tbl = '0;
        mask_tbl = '0;
        for (int s = 0; s < NUM_S; s++) begin
            base_tbl[s] = MAX_ADDR'(SLV_BASE[s*ADDR_BITS +: ADDR_BITS]);
            mask_tbl[s] = MAX_ADDR'(SLV_MASK[s*ADDR_BITS +: ADDR_BITS]);
        end
    end

    axi_rr_arbiter #(.N(NUM_M)) u_arb (
        .req_i   (AWVALID_M),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    // Separate selects: one for the master being arbitrated, one for the registered grant.
    always_comb begin
        arb_addr = '0;
        g_addr   = '0;
        g_id     = '0;
        g_len    = '0;
        g_size   = '0;
        g_burst  = '0;
        g_valid  = 1'b0;
        g_ready  = 1'b0;
        for (int m = 0; m < NUM_M; m++) begin
            if (arb_grant == 4'(m))
                arb_addr = AWADDR_M[m*ADDR_BITS +: ADDR_BITS];
            if (grant_m_q == 4'(m)) begin
                g_addr  = AWADDR_M[m*ADDR_BITS +: ADDR_BITS];
                g_id    = AWID_M[m*ID_BITS +: ID_BITS];
                g_len   = AWLEN_M[m*4 +: 4];
                g_size  = AWSIZE_M[m*3 +: 3];
                g_burst = AWBURST_M[m*2 +: 2];
                g_valid = AWVALID_M[m];
            end
        end
        for (int s = 0; s < NUM_S; s++) begin
            if (grant_s_q == 4'(s))
                g_ready = AWREADY_S[s];
        end
    end

    assign dec_slave = decode_slave(MAX_ADDR'(arb_addr), base_tbl, mask_tbl, NUM_S,
                                    4'(DEFAULT_SLAVE));

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_m_d = grant_m_q;
        grant_s_d = grant_s_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_m_d = arb_grant;
                    grant_s_d = dec_slave;
                    rr_ptr_d  = (arb_grant == 4'(NUM_M-1)) ? 4'd0 : arb_grant + 4'd1;
                    state_d   = AW;
                end
            end
            AW: begin
                if (g_valid && g_ready)
                    state_d = W;
            end
            W: begin
                if (w_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_m_q <= '0;
            grant_s_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_m_q <= grant_m_d;
            grant_s_q <= grant_s_d;
        end
    end

    // Routing exists only in AW, so reset (which forces IDLE) zeroes every AW output at once.
    always_comb begin
        AWREADY_M = '0;
        AWID_S    = '0;
        AWADDR_S  = '0;
        AWLEN_S   = '0;
        AWSIZE_S  = '0;
        AWBURST_S = '0;
        AWVALID_S = '0;
        if (state_q == AW) begin
            for (int s = 0; s < NUM_S; s++) begin
                if (grant_s_q == 4'(s)) begin
                    AWVALID_S[s]                       = g_valid;
                    AWID_S[s*IDS_BITS +: IDS_BITS]     = IDS_BITS'({grant_m_q, g_id});
                    AWADDR_S[s*ADDR_BITS +: ADDR_BITS] = g_addr;
                    AWLEN_S[s*4 +: 4]                  = g_len;
                    AWSIZE_S[s*3 +: 3]                 = g_size;
                    AWBURST_S[s*2 +: 2]                = g_burst;
                end
            end
            for (int m = 0; m < NUM_M; m++) begin
                if (grant_m_q == 4'(m))
                    AWREADY_M[m] = g_ready;
            end
        end
    end

    assign grant_valid = (state_q != IDLE);
    assign grant_m     = grant_m_q;
    assign grant_s     = grant_s_q;

endmodule
